// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter
// Brief    : Buffers one result per execution unit and drains them round-robin
//            onto the single register-file write port.
// Revision : 1.0
// ============================================================================
module writeback_arbiter #(
  parameter int NSRC = 3,
  parameter int xlen = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NSRC-1:0]            src_valid,
  output logic [NSRC-1:0]            src_ready,
  input  logic [NSRC-1:0][4:0]       src_rd,
  input  logic [NSRC-1:0][xlen-1:0]  src_data,
  input  logic                       flush,
  output logic                       w_valid,
  output logic [4:0]                 w_ad,
  output logic [xlen-1:0]            w_data
);

  localparam int              PW   = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [PW-1:0]   LAST = PW'(NSRC - 1);

  logic [NSRC-1:0]            buf_v;
  logic [NSRC-1:0][4:0]       buf_rd;
  logic [NSRC-1:0][xlen-1:0]  buf_data;
  logic [PW-1:0]              rr_ptr;

  logic [NSRC-1:0]            grant;
  logic [PW-1:0]              gidx;
  logic [PW-1:0]              cand;
  logic                       any_grant;

  // Search starts one past the last winner so every full buffer is served
  // within NSRC cycles.
  always_comb begin
    grant     = '0;
    gidx      = rr_ptr;
    cand      = rr_ptr;
    any_grant = 1'b0;
    for (int k = 1; k <= NSRC; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NSRC);
      if (!any_grant && buf_v[cand]) begin
        grant[cand] = 1'b1;
        gidx        = cand;
        any_grant   = 1'b1;
      end
    end
  end

  // A granted buffer drains this edge, so it may refill in the same cycle.
  assign src_ready = {NSRC{!flush}} & (~buf_v | grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_v    <= '0;
      buf_rd   <= '0;
      buf_data <= '0;
      rr_ptr   <= LAST;
      w_valid  <= 1'b0;
      w_ad     <= 5'd0;
      w_data   <= '0;
    end else if (flush) begin
      buf_v   <= '0;
      w_valid <= 1'b0;
    end else begin
      w_valid <= any_grant;
      if (any_grant) begin
        w_ad   <= buf_rd[gidx];
        w_data <= buf_data[gidx];
        rr_ptr <= gidx;
      end
      for (int i = 0; i < NSRC; i++) begin
        if (grant[i]) begin
          buf_v[i] <= 1'b0;
        end
        // Writes to x0 are accepted but never buffered.
        if (src_valid[i] && src_ready[i] && (src_rd[i] != 5'd0)) begin
          buf_v[i]    <= 1'b1;
          buf_rd[i]   <= src_rd[i];
          buf_data[i] <= src_data[i];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_arbiter
// Brief    : Directed vector table plus streaming and async-reset sequences.
// Revision : 1.0
// ============================================================================
module tb_writeback_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        src_valid;
  logic [2:0]        src_ready;
  logic [2:0][4:0]   src_rd;
  logic [2:0][31:0]  src_data;
  logic              flush;
  logic              w_valid;
  logic [4:0]        w_ad;
  logic [31:0]       w_data;

  int errors = 0;
  int checks = 0;

  writeback_arbiter #(.NSRC(3), .xlen(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .flush     (flush),
    .w_valid   (w_valid),
    .w_ad      (w_ad),
    .w_data    (w_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       v;
    logic [2:0][4:0]  rd;
    logic [2:0][31:0] d;
    logic             fl;
    logic [2:0]       rdy;
    logic             wv;
    logic [4:0]       ad;
    logic [31:0]      wd;
  } vec_t;

  typedef struct {
    logic [4:0]  ad;
    logic [31:0] wd;
    int          cyc;
  } wr_t;

  vec_t vecs[$];
  wr_t  wrs[$];

  function automatic vec_t mk(logic [2:0] v, logic [4:0] r0, logic [4:0] r1, logic [4:0] r2,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic fl,
                              logic [2:0] rdy, logic wv, logic [4:0] ad, logic [31:0] wd);
    vec_t t;
    t.v = v; t.rd = {r2, r1, r0}; t.d = {d2, d1, d0}; t.fl = fl;
    t.rdy = rdy; t.wv = wv; t.ad = ad; t.wd = wd;
    return t;
  endfunction

  function automatic vec_t idl(logic [2:0] rdy, logic wv, logic [4:0] ad, logic [31:0] wd);
    return mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, rdy, wv, ad, wd);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    src_valid = 3'b000;
    src_rd    = '0;
    src_data  = '0;
    flush     = 1'b0;
  endtask

  initial begin
    int na, nc, cyc;
    logic hs0, hs2;

    rst_n = 1'b0;
    drive_idle();

    // Three-way contention, second round, lone ALU write, x0 drop,
    // same-edge refill, flush with pending write, post-flush write.
    vecs.push_back(idl(3'b111, 1'b0, 5'd0, 32'h0));
    vecs.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3, 1'b0, 3'b111, 1'b0, 5'd0, 32'h0));
    vecs.push_back(idl(3'b001, 1'b1, 5'd1, 32'hA1));
    vecs.push_back(idl(3'b011, 1'b1, 5'd2, 32'hA2));
    vecs.push_back(idl(3'b111, 1'b1, 5'd3, 32'hA3));
    vecs.push_back(mk(3'b111, 5'd4, 5'd5, 5'd6, 32'hB4, 32'hB5, 32'hB6, 1'b0, 3'b111, 1'b0, 5'd3, 32'hA3));
    vecs.push_back(idl(3'b001, 1'b1, 5'd4, 32'hB4));
    vecs.push_back(idl(3'b011, 1'b1, 5'd5, 32'hB5));
    vecs.push_back(idl(3'b111, 1'b1, 5'd6, 32'hB6));
    vecs.push_back(idl(3'b111, 1'b0, 5'd6, 32'hB6));
    vecs.push_back(mk(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 3'b111, 1'b0, 5'd6, 32'hB6));
    vecs.push_back(idl(3'b111, 1'b1, 5'd5, 32'hDEADBEEF));
    vecs.push_back(idl(3'b111, 1'b0, 5'd5, 32'hDEADBEEF));
    vecs.push_back(mk(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h0, 1'b0, 3'b111, 1'b0, 5'd5, 32'hDEADBEEF));
    for (int i = 0; i < 4; i++) vecs.push_back(idl(3'b111, 1'b0, 5'd5, 32'hDEADBEEF));
    vecs.push_back(mk(3'b001, 5'd7, 5'd0, 5'd0, 32'hC7, 32'h0, 32'h0, 1'b0, 3'b111, 1'b0, 5'd5, 32'hDEADBEEF));
    vecs.push_back(mk(3'b001, 5'd8, 5'd0, 5'd0, 32'hC8, 32'h0, 32'h0, 1'b0, 3'b111, 1'b1, 5'd7, 32'hC7));
    vecs.push_back(idl(3'b111, 1'b1, 5'd8, 32'hC8));
    vecs.push_back(idl(3'b111, 1'b0, 5'd8, 32'hC8));
    vecs.push_back(mk(3'b111, 5'd9, 5'd10, 5'd11, 32'hD9, 32'hDA, 32'hDB, 1'b0, 3'b111, 1'b0, 5'd8, 32'hC8));
    vecs.push_back(mk(3'b010, 5'd0, 5'd13, 5'd0, 32'h0, 32'hDD, 32'h0, 1'b0, 3'b010, 1'b1, 5'd10, 32'hDA));
    vecs.push_back(mk(3'b111, 5'd14, 5'd15, 5'd16, 32'hE4, 32'hE5, 32'hE6, 1'b1, 3'b000, 1'b0, 5'd10, 32'hDA));
    vecs.push_back(idl(3'b111, 1'b0, 5'd10, 32'hDA));
    vecs.push_back(idl(3'b111, 1'b0, 5'd10, 32'hDA));
    vecs.push_back(mk(3'b100, 5'd0, 5'd0, 5'd17, 32'h0, 32'h0, 32'hDE, 1'b0, 3'b111, 1'b0, 5'd10, 32'hDA));
    vecs.push_back(idl(3'b111, 1'b1, 5'd17, 32'hDE));
    vecs.push_back(idl(3'b111, 1'b0, 5'd17, 32'hDE));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      src_valid = vecs[i].v;
      src_rd    = vecs[i].rd;
      src_data  = vecs[i].d;
      flush     = vecs[i].fl;
      #1 chk($sformatf("v%0d src_ready", i), 64'(src_ready), 64'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d w_valid", i), 64'(w_valid), 64'(vecs[i].wv));
      chk($sformatf("v%0d w_ad", i),    64'(w_ad),    64'(vecs[i].ad));
      chk($sformatf("v%0d w_data", i),  64'(w_data),  64'(vecs[i].wd));
    end

    // ALU and CSR both stream 12 results; writes must alternate back to back.
    na = 0; nc = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      drive_idle();
      src_valid[0] = (na < 12);
      src_rd[0]    = 5'(1 + na);
      src_data[0]  = 32'hA000 + 32'(na);
      src_valid[2] = (nc < 12);
      src_rd[2]    = 5'(13 + nc);
      src_data[2]  = 32'hC000 + 32'(nc);
      #1;
      hs0 = src_valid[0] & src_ready[0];
      hs2 = src_valid[2] & src_ready[2];
      @(posedge clk);
      #1;
      if (hs0) na++;
      if (hs2) nc++;
      if (w_valid) wrs.push_back('{ad: w_ad, wd: w_data, cyc: cyc});
    end
    drive_idle();
    chk("stream write count", 64'(wrs.size()), 64'd24);
    for (int k = 0; k < 12; k++) begin
      if (2*k+1 < wrs.size()) begin
        chk($sformatf("stream alu%0d ad", k),   64'(wrs[2*k].ad),   64'(1 + k));
        chk($sformatf("stream alu%0d data", k), 64'(wrs[2*k].wd),   64'(32'hA000 + k));
        chk($sformatf("stream csr%0d ad", k),   64'(wrs[2*k+1].ad), 64'(13 + k));
        chk($sformatf("stream csr%0d data", k), 64'(wrs[2*k+1].wd), 64'(32'hC000 + k));
      end
    end
    for (int j = 1; j < wrs.size(); j++)
      chk($sformatf("stream gap %0d", j), 64'(wrs[j].cyc - wrs[j-1].cyc), 64'd1);

    // Asynchronous reset between edges with a result still buffered.
    @(negedge clk);
    src_valid   = 3'b011;
    src_rd[0]   = 5'd20; src_data[0] = 32'h20;
    src_rd[1]   = 5'd21; src_data[1] = 32'h21;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    chk("pre-reset w_valid", 64'(w_valid), 64'd1);
    chk("pre-reset w_ad",    64'(w_ad),    64'd20);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset w_valid",   64'(w_valid),   64'd0);
    chk("async reset w_ad",      64'(w_ad),      64'd0);
    chk("async reset w_data",    64'(w_data),    64'd0);
    chk("async reset src_ready", 64'(src_ready), 64'b111);
    @(negedge clk);
    rst_n       = 1'b1;
    src_valid   = 3'b011;
    src_rd[0]   = 5'd22; src_data[0] = 32'h22;
    src_rd[1]   = 5'd23; src_data[1] = 32'h23;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    chk("post-reset first w_valid", 64'(w_valid), 64'd1);
    chk("post-reset first w_ad",    64'(w_ad),     64'd22);
    chk("post-reset first w_data",  64'(w_data),   64'h22);
    @(posedge clk);
    #1;
    chk("post-reset second w_ad",   64'(w_ad),     64'd23);
    @(posedge clk);
    #1;
    chk("post-reset idle w_valid",  64'(w_valid),  64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
